// File: rtl/sram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a shared SRAM slave port.
// A watchdog ends any transfer the slave does not ack within TIMEOUT cycles.
module sram_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned AW      = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [31:0]   m0_dat_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [31:0]   m1_dat_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic          s_ack_i,
    input  logic [31:0]   s_dat_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_n;
    logic        grant, grant_n;
    logic        last, last_n;
    logic [15:0] tmo_cnt, tmo_n;

    logic          req0, req1;
    logic          g_cyc, g_stb, g_we;
    logic [3:0]    g_sel;
    logic [AW-1:0] g_adr;
    logic [31:0]   g_dat;
    logic          xfer_ack, xfer_err, tmo_hit;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    assign g_cyc = grant ? m1_cyc_i : m0_cyc_i;
    assign g_stb = grant ? m1_stb_i : m0_stb_i;
    assign g_we  = grant ? m1_we_i  : m0_we_i;
    assign g_sel = grant ? m1_sel_i : m0_sel_i;
    assign g_adr = grant ? m1_adr_i : m0_adr_i;
    assign g_dat = grant ? m1_dat_i : m0_dat_i;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            grant   <= 1'b0;
            last    <= 1'b1;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            last    <= last_n;
            tmo_cnt <= tmo_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        last_n   = last;
        tmo_n    = tmo_cnt;
        xfer_ack = 1'b0;
        xfer_err = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;

        case (state)
            IDLE: begin
                tmo_n = '0;
                if (req0 && req1) begin
                    grant_n = ~last;
                    state_n = BUSY;
                end else if (req0) begin
                    grant_n = 1'b0;
                    state_n = BUSY;
                end else if (req1) begin
                    grant_n = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                s_cyc_o  = g_cyc;
                s_stb_o  = g_stb;
                s_we_o   = g_we;
                s_sel_o  = g_sel;
                s_adr_o  = g_adr;
                s_dat_o  = g_dat;
                // ack beats a coincident timeout; a dropped cyc ends silently
                xfer_ack = g_cyc & g_stb & s_ack_i;
                xfer_err = g_cyc & g_stb & ~s_ack_i & tmo_hit;
                if (!g_cyc || xfer_ack || tmo_hit) begin
                    state_n = IDLE;
                    last_n  = grant;
                    tmo_n   = '0;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign m0_ack_o = xfer_ack & ~grant;
    assign m1_ack_o = xfer_ack & grant;
    assign m0_err_o = xfer_err & ~grant;
    assign m1_err_o = xfer_err & grant;
    assign m0_dat_o = (state == BUSY && !grant) ? s_dat_i : '0;
    assign m1_dat_o = (state == BUSY &&  grant) ? s_dat_i : '0;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Directed bench for sram_wb_arbiter; instance a uses TIMEOUT=4, instance b TIMEOUT=3,
// both driven from the same master/slave stimulus.
module tb_sram_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat, s_dat;

    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
    logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat;
    logic [3:0]  a_s_sel;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
    logic [31:0] b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
    logic [3:0]  b_s_sel;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] RR_STB  = 8'b0101_0101;
    localparam logic [7:0] RR_ACK0 = 8'b0001_0001;
    localparam logic [7:0] RR_ACK1 = 8'b0100_0100;

    sram_wb_arbiter #(.TIMEOUT(4), .AW(32)) dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m0_dat_o(a_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .m1_dat_o(a_m1_dat),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
        .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_ack_i(s_ack), .s_dat_i(s_dat)
    );

    sram_wb_arbiter #(.TIMEOUT(3), .AW(32)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m0_dat_o(b_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .m1_dat_o(b_m1_dat),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
        .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_ack_i(s_ack), .s_dat_i(s_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_dat = '0;
        s_ack = 0; s_dat = '0;
    endtask

    // Entered and left at a falling edge; reset released away from the rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        m0_adr = 32'h44; m0_sel = 4'hF; m0_dat = 32'h1234_5678; s_dat = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_m0_ack, a_m0_err, a_m0_dat, a_m1_ack, a_m1_err, a_m1_dat, a_s_cyc, a_s_stb,
             a_s_we, a_s_sel, a_s_adr, a_s_dat} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_a: got nonzero output (s_cyc=%b ack0=%b) expected all 0", a_s_cyc, a_m0_ack);
        end
        n_checks++;
        if ({b_m0_ack, b_m0_err, b_m0_dat, b_m1_ack, b_m1_err, b_m1_dat, b_s_cyc, b_s_stb,
             b_s_we, b_s_sel, b_s_adr, b_s_dat} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_b: got nonzero output (s_cyc=%b ack0=%b) expected all 0", b_s_cyc, b_m0_ack);
        end
        do_reset();
    endtask

    task automatic test_write();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h10; m0_dat = 32'hA5A5_A5A5;
        @(negedge clk);
        n_checks++;
        if ({a_s_cyc, a_s_stb, a_s_we, a_s_sel, a_s_adr, a_s_dat} !== {3'b111, 4'hF, 32'h10, 32'hA5A5_A5A5}) begin
            n_fail++; $display("FAIL write_mirror: got stb=%b adr=%h dat=%h expected stb=1 adr=10 dat=a5a5a5a5", a_s_stb, a_s_adr, a_s_dat);
        end
        n_checks++;
        if (a_m0_ack !== 1'b0) begin
            n_fail++; $display("FAIL write_early_ack: got %b expected 0", a_m0_ack);
        end
        @(posedge clk);
        @(posedge clk); #1;
        s_ack = 1;
        @(negedge clk);
        n_checks++;
        if ({a_m0_ack, a_m0_err} !== 2'b10) begin
            n_fail++; $display("FAIL write_ack: got ack=%b err=%b expected ack=1 err=0", a_m0_ack, a_m0_err);
        end
        n_checks++;
        if ({a_m1_ack, a_m1_err, a_m1_dat} !== '0) begin
            n_fail++; $display("FAIL write_m1_quiet: got ack=%b err=%b dat=%h expected 0", a_m1_ack, a_m1_err, a_m1_dat);
        end
        @(posedge clk); #1;
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        @(negedge clk);
        n_checks++;
        if ({a_m0_ack, a_s_cyc} !== 2'b00) begin
            n_fail++; $display("FAIL write_after: got ack=%b s_cyc=%b expected 0 0", a_m0_ack, a_s_cyc);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
        s_ack = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_s_stb, a_m0_ack, a_m1_ack} !== {RR_STB[i], RR_ACK0[i], RR_ACK1[i]}) begin
                n_fail++; $display("FAIL rr_cycle%0d: got stb/ack0/ack1=%b%b%b expected %b%b%b",
                                   i, a_s_stb, a_m0_ack, a_m1_ack, RR_STB[i], RR_ACK0[i], RR_ACK1[i]);
            end
            if (RR_STB[i]) begin
                n_checks++;
                if (a_s_adr !== (RR_ACK0[i] ? 32'h100 : 32'h200)) begin
                    n_fail++; $display("FAIL rr_adr%0d: got %h expected %h", i, a_s_adr, RR_ACK0[i] ? 32'h100 : 32'h200);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_m1_err, a_m1_ack, a_m0_ack, a_m0_err} !== {(i == 4), 3'b000}) begin
                n_fail++; $display("FAIL tmo_busy%0d: got err1=%b ack1=%b ack0=%b err0=%b expected err1=%b others 0",
                                   i, a_m1_err, a_m1_ack, a_m0_ack, a_m0_err, (i == 4));
            end
        end
        @(negedge clk);
        n_checks++;
        if ({a_s_cyc, a_m1_err, a_m1_ack} !== 3'b000) begin
            n_fail++; $display("FAIL tmo_idle: got s_cyc=%b err=%b ack=%b expected 0 0 0", a_s_cyc, a_m1_err, a_m1_ack);
        end
        clear_inputs();
    endtask

    task automatic test_abort();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500;
        @(negedge clk);
        n_checks++;
        if ({a_s_cyc, a_s_adr} !== {1'b1, 32'h400}) begin
            n_fail++; $display("FAIL abort_grant0: got s_cyc=%b adr=%h expected 1 400", a_s_cyc, a_s_adr);
        end
        @(posedge clk); #1;
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        n_checks++;
        if ({a_s_cyc, a_m0_ack, a_m0_err} !== 3'b000) begin
            n_fail++; $display("FAIL abort_drop: got s_cyc=%b ack=%b err=%b expected 0 0 0", a_s_cyc, a_m0_ack, a_m0_err);
        end
        @(negedge clk);
        n_checks++;
        if (a_s_cyc !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got s_cyc=%b expected 0", a_s_cyc);
        end
        @(negedge clk);
        n_checks++;
        if ({a_s_cyc, a_s_adr} !== {1'b1, 32'h500}) begin
            n_fail++; $display("FAIL abort_grant1: got s_cyc=%b adr=%h expected 1 500", a_s_cyc, a_s_adr);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h600;
        m0_adr = 32'h700;
        @(negedge clk);
        n_checks++;
        if ({a_s_cyc, a_s_adr} !== {1'b1, 32'h600}) begin
            n_fail++; $display("FAIL rstmid_busy: got s_cyc=%b adr=%h expected 1 600", a_s_cyc, a_s_adr);
        end
        @(posedge clk); #1;
        rst_n = 0; m0_cyc = 1; m0_stb = 1; s_ack = 1;
        #1;
        n_checks++;
        if ({a_m0_ack, a_m0_err, a_m0_dat, a_m1_ack, a_m1_err, a_m1_dat, a_s_cyc, a_s_stb,
             a_s_we, a_s_sel, a_s_adr, a_s_dat} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got s_cyc=%b ack1=%b adr=%h expected all 0", a_s_cyc, a_m1_ack, a_s_adr);
        end
        @(negedge clk);
        rst_n = 1; s_ack = 0;
        @(negedge clk);
        n_checks++;
        if ({a_s_cyc, a_s_adr} !== {1'b1, 32'h700}) begin
            n_fail++; $display("FAIL rstmid_tie: got s_cyc=%b adr=%h expected 1 700", a_s_cyc, a_s_adr);
        end
        clear_inputs();
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h800;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({b_m1_ack, b_m1_err} !== 2'b00) begin
                n_fail++; $display("FAIL tmoack_wait%0d: got ack=%b err=%b expected 0 0", i, b_m1_ack, b_m1_err);
            end
        end
        @(posedge clk); #1;
        s_ack = 1; s_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({b_m1_ack, b_m1_err} !== 2'b10) begin
            n_fail++; $display("FAIL tmoack_resp: got ack=%b err=%b expected ack=1 err=0", b_m1_ack, b_m1_err);
        end
        n_checks++;
        if ({b_m1_dat, b_m0_dat} !== {32'hDEAD_BEEF, 32'h0}) begin
            n_fail++; $display("FAIL tmoack_dat: got m1_dat=%h m0_dat=%h expected deadbeef 0", b_m1_dat, b_m0_dat);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if ({b_m1_ack, b_m1_err, b_s_cyc} !== 3'b000) begin
            n_fail++; $display("FAIL tmoack_idle: got ack=%b err=%b s_cyc=%b expected 0 0 0", b_m1_ack, b_m1_err, b_s_cyc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_write();
        test_round_robin();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_ack_at_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
